// File: rtl/frame_pkg.sv
// Frame field layout shared by the request and response frame interfaces,
// plus the buffered response entry type and the response frame packer.
package frame_pkg;

   localparam int FRM_WIDTH       = 32;
   localparam int FRM_RSP_BIT     = 31;
   localparam int FRM_INST_MSB    = 30;
   localparam int FRM_INST_LSB    = 28;
   localparam int FRM_ADDR_MSB    = 21;
   localparam int FRM_ADDR_LSB    = 17;
   localparam int FRM_WR_RD_S_BIT = 16;
   localparam int FRM_DATA_MSB    = 15;
   localparam int FRM_DATA_LSB    = 8;
   localparam int FRM_OPID_MSB    = 7;
   localparam int FRM_OPID_LSB    = 0;

   typedef struct packed {
      logic [4:0] addr;
      logic       wr_rd_s;
      logic [7:0] data;
      logic [7:0] op_id;
   } rsp_entry_t;

   // Bits [27:22] stay zero; only the marker, instance and entry fields are set.
   function automatic logic [FRM_WIDTH-1:0] pack_rsp_frame(input logic [2:0]  inst,
                                                           input rsp_entry_t e);
      logic [FRM_WIDTH-1:0] f;
      f                              = '0;
      f[FRM_RSP_BIT]                 = 1'b1;
      f[FRM_INST_MSB:FRM_INST_LSB]   = inst;
      f[FRM_ADDR_MSB:FRM_ADDR_LSB]   = e.addr;
      f[FRM_WR_RD_S_BIT]             = e.wr_rd_s;
      f[FRM_DATA_MSB:FRM_DATA_LSB]   = e.data;
      f[FRM_OPID_MSB:FRM_OPID_LSB]   = e.op_id;
      return f;
   endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO; slot0 is always the head. A push to a full FIFO
// is ignored unless a pop happens in the same cycle.
module rsp_fifo2
   import frame_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  rsp_entry_t push_entry,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output rsp_entry_t head
);

   logic [1:0] count_q, count_d;
   logic [1:0] count_after_pop;
   logic       do_pop;
   rsp_entry_t slot0_q, slot0_d;
   rsp_entry_t slot1_q, slot1_d;

   always_comb begin
      do_pop          = pop && (count_q != 2'd0);
      count_after_pop = do_pop ? (count_q - 2'd1) : count_q;
      slot0_d         = do_pop ? slot1_q : slot0_q;
      slot1_d         = slot1_q;
      count_d         = count_after_pop;
      if (push) begin
         case (count_after_pop)
            2'd0: begin
               slot0_d = push_entry;
               count_d = 2'd1;
            end
            2'd1: begin
               slot1_d = push_entry;
               count_d = 2'd2;
            end
            default: count_d = count_after_pop;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
   end

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign head  = slot0_q;

endmodule

// File: rtl/frame_rsp_sif.sv
// Response frame interface: buffers per-instance responses, arbitrates them
// round-robin and drives packed 32-bit frames through a registered valid/ready port.
module frame_rsp_sif
   import frame_pkg::*;
#(
   parameter int NUM_SW_INST = 5,
   parameter int W_WIDTH     = 8,
   parameter int FRAME_WIDTH = 32
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SW_INST-1:0]       rsp_valid,
   input  logic [NUM_SW_INST*5-1:0]     rsp_addr,
   input  logic [NUM_SW_INST-1:0]       rsp_wr_rd_s,
   input  logic [NUM_SW_INST*W_WIDTH-1:0] rsp_data,
   input  logic [NUM_SW_INST*8-1:0]     rsp_op_id,
   output logic [FRAME_WIDTH-1:0]       frame_out,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [NUM_SW_INST-1:0]       ovf_sticky,
   input  logic                         ovf_clr
);

   localparam int MAX_INST = 8;

   if (W_WIDTH != 8) begin : g_chk_w_width
      $error("frame_rsp_sif: W_WIDTH must be 8");
   end
   if (FRAME_WIDTH != 32) begin : g_chk_frame_width
      $error("frame_rsp_sif: FRAME_WIDTH must be 32");
   end
   if (NUM_SW_INST < 1 || NUM_SW_INST > MAX_INST) begin : g_chk_num_inst
      $error("frame_rsp_sif: NUM_SW_INST must be 1..8");
   end

   logic [MAX_INST-1:0]    nonempty;
   rsp_entry_t             head_arr [MAX_INST];
   logic [NUM_SW_INST-1:0] fifo_full;
   logic [NUM_SW_INST-1:0] fifo_pop;
   logic [NUM_SW_INST-1:0] ovf_set;

   logic                   grant_vld;
   logic [2:0]             grant_idx;
   logic [3:0]             scan;
   logic                   can_load;
   logic                   load_en;

   logic [2:0]             rr_q, rr_d;
   logic                   frame_valid_q, frame_valid_d;
   logic [FRAME_WIDTH-1:0] frame_q, frame_d;
   logic [NUM_SW_INST-1:0] ovf_q, ovf_d;

   // Vectors are padded to 8 so the 3-bit grant index selects them directly.
   for (genvar i = 0; i < MAX_INST; i++) begin : g_inst
      if (i < NUM_SW_INST) begin : g_fifo
         rsp_entry_t entry;
         logic       empty;

         assign entry = '{addr:    rsp_addr[5*i +: 5],
                          wr_rd_s: rsp_wr_rd_s[i],
                          data:    rsp_data[W_WIDTH*i +: W_WIDTH],
                          op_id:   rsp_op_id[8*i +: 8]};

         rsp_fifo2 u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (rsp_valid[i]),
            .push_entry (entry),
            .pop        (fifo_pop[i]),
            .full       (fifo_full[i]),
            .empty      (empty),
            .head       (head_arr[i])
         );

         assign nonempty[i] = !empty;
         assign fifo_pop[i] = load_en && (grant_idx == 3'(i));
         assign ovf_set[i]  = rsp_valid[i] && fifo_full[i] && !fifo_pop[i];
      end else begin : g_tie
         assign nonempty[i] = 1'b0;
         assign head_arr[i] = '0;
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan      = '0;
      for (int k = 0; k < NUM_SW_INST; k++) begin
         scan = {1'b0, rr_q} + 4'(k);
         if (scan >= 4'(NUM_SW_INST)) begin
            scan = scan - 4'(NUM_SW_INST);
         end
         if (!grant_vld && nonempty[scan[2:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan[2:0];
         end
      end
   end

   always_comb begin
      can_load      = !frame_valid_q || frame_ready;
      load_en       = can_load && grant_vld;
      frame_valid_d = frame_valid_q;
      frame_d       = frame_q;
      rr_d          = rr_q;
      if (can_load) begin
         frame_valid_d = grant_vld;
         if (grant_vld) begin
            frame_d = pack_rsp_frame(grant_idx, head_arr[grant_idx]);
            rr_d    = (({1'b0, grant_idx} + 4'd1) == 4'(NUM_SW_INST)) ? 3'd0
                                                                     : grant_idx + 3'd1;
         end
      end
      // A same-cycle overflow beats the clear.
      ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_valid_q <= 1'b0;
         frame_q       <= '0;
         rr_q          <= '0;
         ovf_q         <= '0;
      end else begin
         frame_valid_q <= frame_valid_d;
         frame_q       <= frame_d;
         rr_q          <= rr_d;
         ovf_q         <= ovf_d;
      end
   end

   assign frame_out   = frame_q;
   assign frame_valid = frame_valid_q;
   assign ovf_sticky  = ovf_q;

endmodule
